// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch: reads an opcode plus 0-2 argument bytes and
// presents them as a valid/ready bundle. Optional FETCH_CNT_EN adds instr_count.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic [7:0]  opcode,
  input  logic [1:0]  argc,
  output logic [7:0]  arg1,
  output logic [7:0]  arg2,
  output logic [15:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_en,
  input  logic [15:0] branch_off
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, OP_RD, OP_LAT, ARGS, ARG1_LAT, ARG2_LAT, ISSUE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  arg1_q, arg1_d;
  logic [7:0]  arg2_q, arg2_d;
  logic        two_args_q, two_args_d;  // argc[1]; argc=3 behaves as 2
  logic        handshake;

  assign handshake   = (state_q == ISSUE) && instr_ready;
  assign instr_valid = (state_q == ISSUE);
  assign opcode      = opcode_q;
  assign arg1        = arg1_q;
  assign arg2        = arg2_q;
  assign pc_out      = pc_out_q;
  assign mem_addr    = mem_rd ? pc_q : addr_q;
  assign addr_d      = mem_addr;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    opcode_d   = opcode_q;
    arg1_d     = arg1_q;
    arg2_d     = arg2_q;
    two_args_d = two_args_q;
    mem_rd     = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = OP_RD;
      OP_RD: begin
        mem_rd   = 1'b1;
        pc_out_d = pc_q;
        pc_d     = pc_q + 16'd1;
        state_d  = OP_LAT;
      end
      OP_LAT: begin
        opcode_d = mem_data;
        arg1_d   = 8'h00;
        arg2_d   = 8'h00;
        state_d  = ARGS;
      end
      ARGS: begin
        two_args_d = argc[1];
        if (argc == 2'd0) begin
          state_d = ISSUE;
        end else begin
          mem_rd  = 1'b1;
          pc_d    = pc_q + 16'd1;
          state_d = ARG1_LAT;
        end
      end
      ARG1_LAT: begin
        arg1_d = mem_data;
        if (two_args_q) begin
          mem_rd  = 1'b1;
          pc_d    = pc_q + 16'd1;
          state_d = ARG2_LAT;
        end else begin
          state_d = ISSUE;
        end
      end
      ARG2_LAT: begin
        arg2_d  = mem_data;
        state_d = ISSUE;
      end
      ISSUE: if (instr_ready) begin
        if (branch_en) pc_d = pc_out_q + branch_off;
        state_d = OP_RD;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= 16'h0000;
      addr_q     <= 16'h0000;
      pc_out_q   <= 16'h0000;
      opcode_q   <= 8'h00;
      arg1_q     <= 8'h00;
      arg2_q     <= 8'h00;
      two_args_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      pc_out_q   <= pc_out_d;
      opcode_q   <= opcode_d;
      arg1_q     <= arg1_d;
      arg2_q     <= arg2_d;
      two_args_q <= two_args_d;
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] count_q, count_d;

  assign count_d     = count_q + {31'd0, handshake};
  assign instr_count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 32'd0;
    else     count_q <= count_d;
  end
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a program-level reference model
// predicts each bundle and every opcode fetch address; a monitor checks them.
module tb_instr_fetch;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [15:0] pc;
    logic [3:0]  lat;
  } bundle_t;

  typedef struct packed {
    logic        en;
    logic [15:0] off;
  } br_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  opcode;
  logic [1:0]  argc;
  logic [7:0]  arg1, arg2;
  logic [15:0] pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_en = 1'b0;
  logic [15:0] branch_off = 16'h0000;
`ifdef FETCH_CNT_EN
  logic [31:0] instr_count;
`endif

  logic [7:0] mem [0:65535];
  logic [1:0] argc_tab [0:255];

  bundle_t     expq[$];
  br_t         bq[$];
  br_t         plan_q[$];
  logic [15:0] pcq[$];

  int n_cmp = 0;
  int n_err = 0;
  int ready_pct = 100;
  int hs_cnt = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .opcode(opcode), .argc(argc), .arg1(arg1), .arg2(arg2),
    .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_en(branch_en), .branch_off(branch_off)
`ifdef FETCH_CNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  // Decoder stand-in and program memory with one-cycle read latency.
  assign argc = argc_tab[opcode];
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 8'($urandom);

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the program from pc 0 using the branch plan.
  task automatic build(input int n);
    logic [15:0] pc;
    bundle_t     b;
    br_t         br;
    int          k;
    pc = 16'h0000;
    for (int i = 0; i < n; i++) begin
      br   = plan_q.pop_front();
      b.op = mem[pc];
      k    = int'(argc_tab[b.op]);
      if (k == 3) k = 2;
      b.a1  = (k >= 1) ? mem[pc + 16'd1] : 8'h00;
      b.a2  = (k == 2) ? mem[pc + 16'd2] : 8'h00;
      b.pc  = pc;
      b.lat = 4'(3 + k);
      expq.push_back(b);
      bq.push_back(br);
      pcq.push_back(pc);
      pc = br.en ? pc + br.off : pc + 16'(1 + k);
    end
    pcq.push_back(pc);
  endtask

  task automatic plan(input logic en, input logic [15:0] off);
    br_t br;
    br.en  = en;
    br.off = off;
    plan_q.push_back(br);
  endtask

  task automatic check_reset_vals();
    check("rst_mem_addr", 40'(mem_addr), 40'h0);
    check("rst_mem_rd", 40'(mem_rd), 40'h0);
    check("rst_bundle", {opcode, arg1, arg2, pc_out}, 40'h0);
    check("rst_valid", 40'(instr_valid), 40'h0);
`ifdef FETCH_CNT_EN
    check("rst_count", 40'(instr_count), 40'h0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_vals();
    expq.delete();
    bq.delete();
    pcq.delete();
    plan_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_phase(input int pct, input int extra_starts);
    int cyc;
    ready_pct = pct;
    pulse_start();
    for (int i = 0; i < extra_starts; i++) begin
      repeat (7 + i) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    cyc = 0;
    while ((expq.size() != 0 || pcq.size() != 0) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check("phase_done_timeout", 40'(expq.size() + pcq.size()), 40'h0);
    repeat (2) @(posedge clk);
`ifdef FETCH_CNT_EN
    check("instr_count", 40'(instr_count), 40'(hs_cnt));
`endif
  endtask

  // Driver: inputs change 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      instr_ready = !rst && (expq.size() != 0) && ($urandom_range(99) < ready_pct);
      if (instr_valid && bq.size() != 0) begin
        branch_en  = bq[0].en;
        branch_off = bq[0].off;
      end else begin
        branch_en  = 1'($urandom);
        branch_off = 16'($urandom);
      end
    end
  end

  // Monitor: samples on the falling edge and checks against the scoreboard.
  initial begin
    bit      expect_op = 0;
    bit      wait_valid = 0;
    bit      idle = 1;
    int      cycle = 0;
    int      t_op = 0;
    bundle_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (rst) begin
        expect_op  = 0;
        wait_valid = 0;
        idle       = 1;
        hs_cnt     = 0;
      end else begin
        if (expect_op) begin
          check("op_rd_strobe", 40'(mem_rd), 40'h1);
          if (pcq.size() != 0) check("op_rd_addr", 40'(mem_addr), 40'(pcq.pop_front()));
          else check("op_rd_unexpected", 40'h1, 40'h0);
          t_op       = cycle;
          expect_op  = 0;
          wait_valid = 1;
        end
        if (instr_valid && expq.size() != 0) begin
          e = expq[0];
          if (wait_valid) check("latency", 40'(cycle - t_op), 40'(e.lat));
          check("bundle", {opcode, arg1, arg2, pc_out}, {e.op, e.a1, e.a2, e.pc});
          check("issue_mem_rd", 40'(mem_rd), 40'h0);
          if (instr_ready) begin
            void'(expq.pop_front());
            void'(bq.pop_front());
            expect_op = 1;
            hs_cnt++;
          end
        end
        if (instr_valid) wait_valid = 0;
        if (start && idle) begin
          expect_op = 1;
          idle      = 0;
        end
      end
    end
  end

  initial begin
    int cyc;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int o = 0; o < 256; o++) argc_tab[o] = 2'($urandom);
    argc_tab[8'h04] = 2'd0;
    argc_tab[8'h11] = 2'd2;
    argc_tab[8'hA7] = 2'd0;
    argc_tab[8'h22] = 2'd3;

    repeat (3) @(posedge clk);
    #3 check_reset_vals();
    rst = 1'b0;

    // Single argc=0 opcode at address 0.
    mem[0] = 8'h04;
    plan(1'b0, 16'h0);
    build(1);
    run_phase(100, 0);
    do_reset();

    // argc=2 opcode; the following fetch must start at 0x0003.
    mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
    plan(1'b0, 16'h0);
    build(1);
    run_phase(100, 0);
    do_reset();

    // Backward branch from 0x0005 by -5, with stalls in ISSUE.
    mem[3] = 8'h04; mem[4] = 8'h04; mem[5] = 8'hA7;
    for (int i = 0; i < 3; i++) plan(1'b0, 16'h0);
    plan(1'b1, 16'hFFFB);
    plan(1'b0, 16'h0);
    build(5);
    run_phase(30, 0);
    do_reset();

    // Branch to 0xFFFF, then sequential fetch wraps to 0x0000; argc=3 acts as 2.
    mem[0] = 8'h04; mem[16'hFFFF] = 8'h22;
    plan(1'b1, 16'hFFFF);
    plan(1'b0, 16'h0);
    plan(1'b0, 16'h0);
    build(3);
    run_phase(70, 0);
    do_reset();

    // Asynchronous reset while in ARG1_LAT.
    mem[0] = 8'h11;
    plan(1'b0, 16'h0);
    build(1);
    ready_pct = 100;
    pulse_start();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_rd && mem_addr == 16'h0001) && cyc < 50);
    check("arg_fetch_timeout", 40'(cyc < 50), 40'h1);
    do_reset();

    // Randomized program with random branches and extra (ignored) start pulses.
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 150; i++) plan(1'($urandom_range(3) == 0), 16'($urandom));
    build(150);
    run_phase(55, 3);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  one-cycle pulse; leaves IDLE and begins fetching at pc 0x0000.
REQ-004 mem_addr  output  16  program-memory byte address.
REQ-005 mem_rd  output  1  read strobe; mem_data valid exactly one cycle after the strobe.
REQ-006 mem_data  input  8  program-memory read data.
REQ-007 opcode  output  8  registered opcode; drives the decoder's opcode input.
REQ-008 argc  input  2  argument-byte count returned combinationally by the decoder for opcode.
REQ-009 arg1, arg2  output  8 each  first and second argument bytes, in program order.
REQ-010 pc_out  output  16  byte address of the current opcode.
REQ-011 instr_valid  output  1  instruction bundle (opcode, arg1, arg2, pc_out) is complete.
REQ-012 instr_ready  input  1  downstream accepts the bundle.
REQ-013 branch_en  input  1  redirect fetch; sampled only on the handshake cycle.
REQ-014 branch_off  input  16  signed branch offset, relative to pc_out.
REQ-015 instr_count  output  32  accepted-instruction count; present only with FETCH_CNT_EN.

Function
REQ-016 States: IDLE, OP_RD, OP_LAT, ARGS, ARG1_LAT, ARG2_LAT, ISSUE.
REQ-017 IDLE: mem_rd=0; start=1 -> OP_RD.
REQ-018 OP_RD: mem_rd=1, mem_addr=pc, pc_out<=pc, pc<=pc+1 -> OP_LAT.
REQ-019 OP_LAT: opcode<=mem_data -> ARGS.
REQ-020 ARGS: argc_r<=argc; if argc=0 -> ISSUE. Otherwise: mem_rd=1, mem_addr=pc, pc<=pc+1 -> ARG1_LAT.
REQ-021 ARG1_LAT: arg1<=mem_data. If argc_r[1]=1: mem_rd=1, mem_addr=pc, pc<=pc+1 -> ARG2_LAT. Otherwise -> ISSUE. argc=3 is handled as 2.
REQ-022 ARG2_LAT: arg2<=mem_data -> ISSUE.
REQ-023 Unused argument registers are cleared to 0x00 when the opcode is latched.
REQ-024 ISSUE: instr_valid=1. The bundle holds stable and mem_rd stays 0 while instr_ready=0.
REQ-025 Handshake is instr_valid & instr_ready. On handshake: if branch_en, pc<=pc_out+branch_off (mod 2^16), else pc unchanged. Then -> OP_RD.
REQ-026 branch_en outside the handshake cycle is ignored.
REQ-027 Latency from OP_RD entry to instr_valid: 3 cycles (argc=0), 4 cycles (argc=1), 5 cycles (argc=2).
REQ-028 pc arithmetic is 16-bit and wraps: 0xFFFF+1 = 0x0000.
REQ-029 start outside IDLE is ignored.
REQ-030 mem_addr holds its last value when mem_rd=0.

Reset
REQ-031 rst=1 forces IDLE immediately (asynchronously), independent of clk.
REQ-032 During reset: pc=0x0000, mem_addr=0x0000, mem_rd=0, opcode=0x00, arg1=arg2=0x00, pc_out=0x0000, instr_valid=0, instr_count=0.
REQ-033 Reset mid-fetch abandons any outstanding read; the mem_data that follows is ignored.

Configuration
REQ-034 Macro FETCH_CNT_EN. Defined: instr_count increments by 1 on each handshake and wraps at 2^32. Undefined: the instr_count port and its counter are absent; all other behaviour is identical.

Verification
REQ-035 mem[0]=0x04, argc=0, start pulse -> instr_valid 3 cycles after OP_RD entry; opcode=0x04, pc_out=0x0000, arg1=arg2=0x00.
REQ-036 mem[0..2]=0x11,0x12,0x34, argc=2, instr_ready=1 -> arg1=0x12, arg2=0x34; next OP_RD mem_addr=0x0003.
REQ-037 Opcode 0xA7 at address 0x0005, branch_en=1, branch_off=0xFFFB on handshake -> next OP_RD mem_addr=0x0000.
REQ-038 instr_ready=0 for 3 cycles in ISSUE -> bundle unchanged, mem_rd=0 throughout; fetch resumes the cycle after instr_ready=1.
REQ-039 Branch to 0xFFFF with an argc=0 opcode accepted -> following OP_RD mem_addr=0x0000 (wrap).
REQ-040 rst asserted in ARG1_LAT -> all outputs at reset values before the next clk edge; with FETCH_CNT_EN, instr_count=0.
